// File: rtl/alu_cmd_issuer_if.sv
// Command/response handshake bundle between the accelerator front-end (master)
// and the ALU command issuer (slave).
interface alu_cmd_issuer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_rd;
    logic [ADDR_W-1:0] cmd_rs1;
    logic [ADDR_W-1:0] cmd_rs2;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;
    logic [ADDR_W-1:0] rsp_rd;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_rd
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_rd
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Issues register-to-register commands to an external combinational ALU,
// writes the result back to a local register file and returns it as a response.
module alu_cmd_issuer #(
    parameter  int DATA_W = 8,
    parameter  int REG_N  = 8,
    localparam int ADDR_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_cmd_issuer_if.slave   bus,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_zero,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [ADDR_W-1:0]             rd_q, rd_d;
    logic [DATA_W-1:0]             alu_a_q, alu_a_d;
    logic [DATA_W-1:0]             alu_b_q, alu_b_d;
    logic [2:0]                    alu_op_q, alu_op_d;
    logic [DATA_W-1:0]             rsp_data_q, rsp_data_d;
    logic                          rsp_zero_q, rsp_zero_d;
    logic [ADDR_W-1:0]             rsp_rd_q, rsp_rd_d;
    logic [REG_N-1:0][DATA_W-1:0]  regs_q, regs_d;

    logic cmd_fire;
    logic rsp_fire;

    assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
    assign rsp_fire = (state_q == RESP) && bus.rsp_ready;

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_rd_d   = rsp_rd_q;
        regs_d     = regs_q;

        if (wr_en)
            regs_d[wr_addr] = wr_data;

        unique case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    // Operands are latched on the accept edge; forward a host write
                    // landing on that same edge so it is seen by the command.
                    alu_a_d  = (wr_en && wr_addr == bus.cmd_rs1) ? wr_data : regs_q[bus.cmd_rs1];
                    alu_b_d  = (wr_en && wr_addr == bus.cmd_rs2) ? wr_data : regs_q[bus.cmd_rs2];
                    alu_op_d = bus.cmd_op;
                    rd_d     = bus.cmd_rd;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                rsp_data_d     = alu_y;
                rsp_zero_d     = alu_zero;
                rsp_rd_d       = rd_q;
                // Assigned after the host write so writeback wins on an address clash.
                regs_d[rd_q]   = alu_y;
                state_d        = RESP;
            end
            RESP: begin
                if (rsp_fire)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_rd_q   <= '0;
            regs_q     <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_rd_q   <= rsp_rd_d;
            regs_q     <= regs_d;
        end
    end

    // Held low while reset is asserted so nothing is accepted before release.
    assign bus.cmd_ready = (state_q == IDLE) && rst_n;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_rd    = rsp_rd_q;

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: behavioural ALU, register-file model,
// expected responses queued at command drive and compared at handshake.
module tb_alu_cmd_issuer;
    localparam int DW = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_issuer_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] alu_a, alu_b, alu_y;
    logic [2:0]    alu_op;
    logic          alu_zero, busy;

    alu_cmd_issuer #(.DATA_W(DW), .REG_N(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_y(alu_y), .alu_zero(alu_zero), .busy(busy)
    );

    function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[2:0];
            3'd6: return a >> b[2:0];
            default: return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
        endcase
    endfunction

    always_comb begin
        alu_y    = alu_f(alu_op, alu_a, alu_b);
        alu_zero = (alu_y == '0);
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          zero;
        logic [AW-1:0] rd;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] mregs [8];
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sbq.size() == 0)
                chk("unexp_rsp", 1, 0);
            else begin
                e = sbq.pop_front();
                chk("sb_data", bus.rsp_data, e.data);
                chk("sb_zero", bus.rsp_zero, e.zero);
                chk("sb_rd",   bus.rsp_rd,   e.rd);
            end
        end
    end

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        mregs[a] = d;
    endtask

    // wph: 0 no host write, 1 host write on the accept edge, 2 on the ISSUE closing edge.
    task automatic issue_cmd(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                             input logic [AW-1:0] rs2, input int wph, input logic [AW-1:0] wa,
                             input logic [DW-1:0] wd, output logic [DW-1:0] od, output logic oz);
        int n;
        exp_t e;
        logic [DW-1:0] res;
        @(negedge clk);
        n = 0;
        while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
        if (wph == 1) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; mregs[wa] = wd; end
        res = alu_f(op, mregs[rs1], mregs[rs2]);
        e.data = res; e.zero = (res == '0); e.rd = rd;
        sbq.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0; wr_en = 1'b0;
        chk("issue_busy", busy, 1);
        chk("issue_cmd_ready", bus.cmd_ready, 0);
        chk("issue_rsp_valid", bus.rsp_valid, 0);
        if (wph == 2) begin wr_en = 1'b1; wr_addr = wa; wr_data = wd; mregs[wa] = wd; end
        mregs[rd] = res;
        @(negedge clk);
        wr_en = 1'b0;
        chk("lat_rsp_valid", bus.rsp_valid, 1);
        od = bus.rsp_data;
        oz = bus.rsp_zero;
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 50) begin @(negedge clk); n++; end
        chk("drain_idle", busy, 0);
        chk("drain_cmd_ready", bus.cmd_ready, 1);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          z;
        logic [DW-1:0] hold;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
        bus.rsp_ready = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 8; i++) mregs[i] = '0;

        #12;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("rel_cmd_ready", bus.cmd_ready, 1);

        // 1: ADD and readback of the written register
        host_wr(1, 8'd5); host_wr(2, 8'd3);
        issue_cmd(3'd0, 3, 1, 2, 0, 0, 0, d, z);
        chk("t1_data", d, 8'd8); chk("t1_zero", z, 0); chk("t1_rd", bus.rsp_rd, 3);
        drain();
        issue_cmd(3'd3, 0, 3, 3, 0, 0, 0, d, z); chk("t1_r3", d, 8'd8); drain();

        // 2: SUB to zero, signed SLT
        issue_cmd(3'd1, 4, 1, 1, 0, 0, 0, d, z); chk("t2_sub", d, 0); chk("t2_zero", z, 1); drain();
        host_wr(5, 8'hFF); host_wr(6, 8'h01);
        issue_cmd(3'd7, 7, 5, 6, 0, 0, 0, d, z); chk("t2_slt", d, 8'd1); drain();

        // 3: wrap and chained writeback with rd==rs
        host_wr(1, 8'h80);
        issue_cmd(3'd0, 1, 1, 1, 0, 0, 0, d, z); chk("t3_wrap", d, 0); chk("t3_zero", z, 1); drain();
        issue_cmd(3'd3, 2, 1, 1, 0, 0, 0, d, z); chk("t3_chain", d, 0); drain();

        // 4: backpressure
        host_wr(1, 8'd5); host_wr(2, 8'd3);
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        issue_cmd(3'd0, 5, 1, 2, 0, 0, 0, d, z);
        hold = d;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.rsp_valid, 1);
            chk("bp_data", bus.rsp_data, hold);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
            chk("bp_busy", busy, 1);
        end
        chk("bp_val", hold, 8'd8);
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("bp_release_ready", bus.cmd_ready, 1);

        // 5: writeback vs host write on the ISSUE closing edge
        issue_cmd(3'd0, 3, 1, 2, 2, 3, 8'hAA, d, z); drain();
        issue_cmd(3'd3, 6, 3, 3, 0, 0, 0, d, z); chk("t5_wb_wins", d, 8'd8); drain();
        issue_cmd(3'd0, 3, 1, 2, 2, 4, 8'hAA, d, z); drain();
        issue_cmd(3'd3, 6, 4, 4, 0, 0, 0, d, z); chk("t5_both", d, 8'hAA); drain();

        // host write on the accept edge is seen by the command
        issue_cmd(3'd0, 7, 1, 2, 1, 1, 8'd10, d, z); chk("fwd_accept", d, 8'd13); drain();

        // random mix
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1) host_wr(3'($urandom_range(0, 7)), 8'($urandom));
            issue_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
                      8'($urandom), d, z);
            drain();
        end

        // 6: reset during RESP
        host_wr(1, 8'h11); host_wr(5, 8'h22);
        @(posedge clk); #1 bus.rsp_ready = 1'b0;
        issue_cmd(3'd3, 2, 1, 5, 0, 0, 0, d, z);
        #2 rst_n = 1'b0;
        #1 chk("t6_async_valid", bus.rsp_valid, 0);
        chk("t6_busy", busy, 0);
        sbq.delete();
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        @(negedge clk); rst_n = 1'b1;
        #1 chk("t6_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_no_stale", bus.rsp_valid, 0);
        end
        issue_cmd(3'd3, 0, 1, 5, 0, 0, 0, d, z); chk("t6_regs_cleared", d, 0); drain();

        @(negedge clk);
        chk("sb_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end
endmodule
